// File: rtl/tdm_demux_4ch.sv
// Receive-side TDM demultiplexer. Tracks the slot of a single lane, rebuilds the
// parallel frame, and flags framing violations with automatic re-acquisition.
module tdm_demux_4ch #(
    parameter int DATA_W = 1,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sync,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         slot,
    output logic                     locked,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    state_t                         state_q, state_d;
    logic [SEL_W-1:0]               slot_q, slot_d;
    logic                           wr_en;
    logic [SEL_W-1:0]               wr_idx;
    logic                           complete;
    logic                           err;
    // The last channel goes straight from in_data into out_data, so only
    // channels 0..NUM_CH-2 need capture storage.
    logic [(NUM_CH-1)*DATA_W-1:0]   cap_q;
    logic [NUM_CH*DATA_W-1:0]       frame_next;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        wr_en    = 1'b0;
        wr_idx   = slot_q;
        complete = 1'b0;
        err      = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        slot_d  = SEL_W'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (in_sync) begin
                        // Sync anywhere but slot 0 abandons the partial frame
                        // and restarts with this beat as channel 0.
                        err    = (slot_q != '0);
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        slot_d = SEL_W'(1);
                    end else if (slot_q == '0) begin
                        err     = 1'b1;
                        state_d = HUNT;
                        slot_d  = '0;
                    end else if (slot_q == LAST_SLOT) begin
                        complete = 1'b1;
                        slot_d   = '0;
                    end else begin
                        wr_en  = 1'b1;
                        slot_d = slot_q + SEL_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign frame_next = {in_data, cap_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            slot_q    <= '0;
            cap_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            out_valid <= complete;
            frame_err <= err;
            if (wr_en) begin
                cap_q[int'(wr_idx)*DATA_W +: DATA_W] <= in_data;
            end
            if (complete) begin
                out_data <= frame_next;
                if (frame_cnt != '1) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign slot   = slot_q;
    assign locked = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios plus a randomized
// run, all compared against an array-based frame model.
module tb_tdm_demux_4ch;

    localparam int DATA_W = 1;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int FW     = NUM_CH * DATA_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sync = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic [SEL_W-1:0]  slot;
    logic              locked;
    logic              frame_err;
    logic [CNT_W-1:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux_4ch #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sync  (in_sync),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .slot     (slot),
        .locked   (locked),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    // Frame model: a lock flag, the position inside the frame, a buffer of
    // received channels and the last delivered frame.
    bit                m_locked;
    int                m_pos;
    logic [DATA_W-1:0] m_buf [NUM_CH];
    logic [FW-1:0]     m_out;
    bit                m_valid;
    bit                m_err;
    int                m_cnt;

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        foreach (m_buf[k]) m_buf[k] = '0;
        m_out    = '0;
        m_valid  = 0;
        m_err    = 0;
        m_cnt    = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [DATA_W-1:0] d);
        m_valid = 0;
        m_err   = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1;
                m_buf[0] = d;
                m_pos    = 1;
            end
        end else if (s) begin
            m_err    = (m_pos != 0);
            m_buf[0] = d;
            m_pos    = 1;
        end else if (m_pos == 0) begin
            m_err    = 1;
            m_locked = 0;
        end else begin
            m_buf[m_pos] = d;
            m_pos++;
            if (m_pos == NUM_CH) begin
                for (int k = 0; k < NUM_CH; k++) m_out[k*DATA_W +: DATA_W] = m_buf[k];
                m_valid = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_pos = 0;
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [DATA_W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
        model_beat(v, s, d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 0;
        in_sync  = 0;
        in_data  = '0;
        rst_n    = 0;
        @(negedge clk);
        rst_n    = 1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_data !== '0)  begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_valid !== 0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (slot !== '0)      begin errors++; $display("FAIL reset_slot got %0d exp 0", slot); end
        checks++; if (locked !== 0)     begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if (frame_err !== 0)  begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    endtask

    task automatic test_basic_frame();
        logic [FW-1:0] f = 4'b0110;
        step(1, 0, 1'b1);
        checks++; if (locked !== 0) begin errors++; $display("FAIL hunt_discard locked got %b exp 0", locked); end
        for (int i = 0; i < NUM_CH; i++) begin
            step(1, (i == 0), f[i]);
            if (i == 0) begin
                checks++; if (slot !== SEL_W'(1) || locked !== 1) begin errors++; $display("FAIL basic_lock slot %0d locked %b exp 1 1", slot, locked); end
            end
            if (i < NUM_CH - 1) begin
                checks++; if (out_valid !== 0) begin errors++; $display("FAIL basic_early_valid beat %0d got %b exp 0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1)         begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'b0110)    begin errors++; $display("FAIL basic_data got %b exp 0110", out_data); end
        checks++; if (frame_cnt !== CNT_W'(1)) begin errors++; $display("FAIL basic_cnt got %0d exp 1", frame_cnt); end
        checks++; if (locked !== 1)            begin errors++; $display("FAIL basic_locked got %b exp 1", locked); end
        step(0, 0, '0);
        checks++; if (out_valid !== 0) begin errors++; $display("FAIL basic_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] frames [3] = '{4'b0110, 4'b1001, 4'b1111};
        int cyc = 0;
        int last_pulse = -1;
        int pulses = 0;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                step(1, (i == 0), frames[n][i]);
                cyc++;
                checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", cyc, out_valid, m_valid); end
                checks++; if (frame_err !== 0)       begin errors++; $display("FAIL b2b_err cyc %0d got %b exp 0", cyc, frame_err); end
                if (out_valid === 1) begin
                    pulses++;
                    checks++; if (out_data !== frames[n]) begin errors++; $display("FAIL b2b_data frame %0d got %b exp %b", n, out_data, frames[n]); end
                    if (last_pulse >= 0) begin
                        checks++; if (cyc - last_pulse != NUM_CH) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", cyc - last_pulse, NUM_CH); end
                    end
                    last_pulse = cyc;
                end
            end
        end
        checks++; if (pulses != 3)                  begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
        checks++; if (frame_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_bubbles();
        logic [FW-1:0] f = 4'b0110;
        logic [SEL_W-1:0] held;
        int pulses = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            step(1, (i == 0), f[i]);
            if (out_valid === 1) pulses++;
            held = slot;
            for (int b = 0; b < 1 + int'($urandom_range(2)); b++) begin
                step(0, $urandom_range(1), DATA_W'($urandom));
                checks++; if (slot !== held)   begin errors++; $display("FAIL bubble_slot got %0d exp %0d", slot, held); end
                checks++; if (out_valid !== 0) begin errors++; $display("FAIL bubble_valid got %b exp 0", out_valid); end
            end
        end
        checks++; if (pulses != 1)          begin errors++; $display("FAIL bubble_pulses got %0d exp 1", pulses); end
        checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL bubble_data got %b exp 0110", out_data); end
    endtask

    task automatic test_missing_sync();
        step(1, 0, 1'b1);
        checks++; if (frame_err !== 1)      begin errors++; $display("FAIL miss_err got %b exp 1", frame_err); end
        checks++; if (locked !== 0)         begin errors++; $display("FAIL miss_locked got %b exp 0", locked); end
        checks++; if (slot !== '0)          begin errors++; $display("FAIL miss_slot got %0d exp 0", slot); end
        checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL miss_data got %b exp 0110", out_data); end
        step(0, 0, '0);
        checks++; if (frame_err !== 0) begin errors++; $display("FAIL miss_pulse got %b exp 0", frame_err); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1'b1);
            checks++; if (locked !== 0 || out_valid !== 0 || frame_err !== 0 || out_data !== 4'b0110)
                begin errors++; $display("FAIL miss_ignore locked %b valid %b err %b data %b exp 0 0 0 0110", locked, out_valid, frame_err, out_data); end
        end
    endtask

    task automatic test_early_sync();
        step(1, 1, 1'b1);
        step(1, 0, 1'b0);
        step(1, 1, 1'b1);
        checks++; if (frame_err !== 1)      begin errors++; $display("FAIL early_err got %b exp 1", frame_err); end
        checks++; if (out_valid !== 0)      begin errors++; $display("FAIL early_valid got %b exp 0", out_valid); end
        checks++; if (slot !== SEL_W'(1))   begin errors++; $display("FAIL early_slot got %0d exp 1", slot); end
        checks++; if (locked !== 1)         begin errors++; $display("FAIL early_locked got %b exp 1", locked); end
        checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL early_hold got %b exp 0110", out_data); end
        step(1, 0, 1'b1);
        checks++; if (out_valid !== 0 || frame_err !== 0) begin errors++; $display("FAIL early_b1 valid %b err %b exp 0 0", out_valid, frame_err); end
        step(1, 0, 1'b0);
        checks++; if (out_valid !== 0) begin errors++; $display("FAIL early_b2 valid got %b exp 0", out_valid); end
        step(1, 0, 1'b1);
        checks++; if (out_valid !== 1)      begin errors++; $display("FAIL early_done valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'b1011) begin errors++; $display("FAIL early_data got %b exp 1011", out_data); end
        checks++; if (out_data !== m_out)   begin errors++; $display("FAIL early_model got %b exp %b", out_data, m_out); end
    endtask

    task automatic test_async_reset();
        step(1, 1, 1'b1);
        step(1, 0, 1'b0);
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_data !== '0 || out_valid !== 0 || slot !== '0 || locked !== 0 || frame_err !== 0 || frame_cnt !== '0)
            begin errors++; $display("FAIL async_reset data %h valid %b slot %0d locked %b err %b cnt %0d exp all 0", out_data, out_valid, slot, locked, frame_err, frame_cnt); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        in_valid = 0;
        step(0, 0, '0);
        checks++; if (locked !== 0 || slot !== '0) begin errors++; $display("FAIL async_release locked %b slot %0d exp 0 0", locked, slot); end
    endtask

    task automatic test_saturation();
        logic [FW-1:0] f;
        for (int n = 0; n < 256; n++) begin
            f = FW'($urandom);
            for (int i = 0; i < NUM_CH; i++) step(1, (i == 0), f[i*DATA_W +: DATA_W]);
            if (n == 254) begin
                checks++; if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255 got %h exp ff", frame_cnt); end
            end
        end
        checks++; if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL sat_256 got %h exp ff", frame_cnt); end
        checks++; if (out_valid !== 1 || out_data !== f) begin errors++; $display("FAIL sat_frame valid %b data %b exp 1 %b", out_valid, out_data, f); end
    endtask

    task automatic test_random();
        bit v, s;
        logic [DATA_W-1:0] d;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(9) < 7);
            s = (m_locked && m_pos == 0 || !m_locked) ? ($urandom_range(9) != 0) : ($urandom_range(19) == 0);
            d = DATA_W'($urandom);
            step(v, s, d);
            checks++; if (out_valid !== m_valid)          begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, m_valid); end
            checks++; if (frame_err !== m_err)            begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, frame_err, m_err); end
            checks++; if (out_data !== m_out)             begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, out_data, m_out); end
            checks++; if (locked !== m_locked)            begin errors++; $display("FAIL rnd_locked cyc %0d got %b exp %b", c, locked, m_locked); end
            checks++; if (slot !== SEL_W'(m_pos))         begin errors++; $display("FAIL rnd_slot cyc %0d got %0d exp %0d", c, slot, m_pos); end
            checks++; if (frame_cnt !== CNT_W'(m_cnt))    begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", c, frame_cnt, m_cnt); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_bubbles();
        test_missing_sync();
        test_early_sync();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
